// File: rtl/writeback_unit.sv
// Writeback stage: merges un-stallable ALU results with buffered load results into a
// single registered register-file write port and tracks pending writes in a scoreboard.
package writeback_unit_pkg;
  typedef enum logic {RF_IDLE = 1'b0, WRITE_REG_DATA = 1'b1} reg_file_op_t;
endpackage

module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_NUM   = 32,
  parameter int LQ_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [4:0]           alu_rd,
  input  logic [WORD_SIZE-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [4:0]           ld_rd,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic [REG_NUM-1:0]   busy,
  output logic                 stall_req,
  output reg_file_op_t         rf_op,
  output logic [4:0]           rf_rd,
  output logic [WORD_SIZE-1:0] rf_data
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [4:0]           lq_rd_mem   [LQ_DEPTH];
  logic [WORD_SIZE-1:0] lq_data_mem [LQ_DEPTH];

  logic                 push, pop, alu_sel, fifo_sel, sel_valid;
  logic [4:0]           sel_rd;
  logic [WORD_SIZE-1:0] sel_data;

  reg_file_op_t         rf_op_reg;
  logic [4:0]           rf_rd_reg;
  logic [WORD_SIZE-1:0] rf_data_reg;
  logic [REG_NUM-1:1]   busy_reg;

  assign ld_ready  = (count_reg < CNT_W'(LQ_DEPTH));
  assign stall_req = (count_reg >= CNT_W'(LQ_DEPTH - 1));

  // Loads to x0 complete the handshake but never occupy a buffer slot.
  assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign alu_sel  = alu_valid && (alu_rd != 5'd0);
  assign fifo_sel = !alu_sel && (count_reg != '0);
  assign pop      = fifo_sel;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = '0;
    if (alu_sel) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (fifo_sel) begin
      sel_valid = 1'b1;
      sel_rd    = lq_rd_mem[rd_ptr_reg];
      sel_data  = lq_data_mem[rd_ptr_reg];
    end
  end

  // Storage carries no reset; validity is tracked solely by count_reg.
  always_ff @(posedge clock) begin
    if (push) begin
      lq_rd_mem[wr_ptr_reg]   <= ld_rd;
      lq_data_mem[wr_ptr_reg] <= ld_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_op_reg   <= RF_IDLE;
      rf_rd_reg   <= 5'd0;
      rf_data_reg <= '0;
    end else begin
      rf_op_reg   <= sel_valid ? WRITE_REG_DATA : RF_IDLE;
      rf_rd_reg   <= sel_rd;
      rf_data_reg <= sel_data;
    end
  end

  assign rf_op   = rf_op_reg;
  assign rf_rd   = rf_rd_reg;
  assign rf_data = rf_data_reg;

  // A new issue to a register wins over the retiring write of its previous producer.
  generate
    for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_busy
      logic set_bit, clr_bit;
      assign set_bit = issue_valid && (issue_rd == 5'(gi));
      assign clr_bit = sel_valid && (sel_rd == 5'(gi));
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) busy_reg[gi] <= 1'b0;
        else        busy_reg[gi] <= set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  assign busy = {busy_reg, 1'b0};

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data width of one register.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers; index width 5.
REQ-003 SHALL have parameter LQ_DEPTH, default 4, load-result buffer entries (power of two, >=2).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alu_valid  input  1  ALU result present this cycle; cannot be back-pressured.
REQ-007 SHALL have ports alu_rd  input  5 and alu_data  input  WORD_SIZE  ALU destination index and result.
REQ-008 SHALL have ports ld_valid  input  1, ld_ready  output  1, ld_rd  input  5, ld_data  input  WORD_SIZE  load-result handshake.
REQ-009 SHALL have ports issue_valid  input  1 and issue_rd  input  5  instruction issued that will write issue_rd.
REQ-010 SHALL have port busy  output  REG_NUM  scoreboard bitmap; bit i = register i has a pending write.
REQ-011 SHALL have port stall_req  output  1  request decode to insert a bubble.
REQ-012 SHALL have ports rf_op  output  reg_file_op_t, rf_rd  output  5, rf_data  output  WORD_SIZE  register-file write port.

Function
REQ-013 Load transfer SHALL occur on a rising edge where ld_valid and ld_ready are both 1; ld_ready = 1 iff buffer count < LQ_DEPTH, independent of same-cycle pop.
REQ-014 Accepted loads SHALL enter a FIFO in order; a load with ld_rd = 0 SHALL be accepted and discarded (not stored).
REQ-015 Each cycle the write source SHALL be: ALU if alu_valid and alu_rd != 0; else FIFO head if FIFO non-empty; else none.
REQ-016 FIFO head SHALL be popped only in a cycle where it is the selected source.
REQ-017 rf_op/rf_rd/rf_data SHALL be registered: selected source in cycle N appears with rf_op = WRITE_REG_DATA in cycle N+1; no source gives rf_op = idle (non-write) encoding, rf_rd = 0, rf_data = 0.
REQ-018 ALU write latency SHALL be exactly 1 cycle; load write latency SHALL be >=2 cycles (2 when FIFO empty and no ALU write in cycle after accept).
REQ-019 rf_rd SHALL never be 0 while rf_op = WRITE_REG_DATA.
REQ-020 Scoreboard bit issue_rd SHALL set on edge where issue_valid = 1 and issue_rd != 0.
REQ-021 Scoreboard bit SHALL clear on the edge where that register is selected as write source (same edge rf outputs load).
REQ-022 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-023 busy[0] SHALL be constant 0.
REQ-024 stall_req SHALL be 1 iff FIFO count >= LQ_DEPTH-1 (combinational from count).
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo LQ_DEPTH.

Reset
REQ-026 While reset = 0: FIFO empty, count 0, busy all 0, rf_op idle, rf_rd 0, rf_data 0, ld_ready 1, stall_req 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered loads and pending scoreboard bits immediately (asynchronously).
REQ-028 First state update after reset deassertion SHALL occur on the next rising clock edge.

Verification
REQ-029 ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 at cycle N -> rf_op=WRITE_REG_DATA, rf_rd=5, rf_data=0x1234 at N+1; idle at N+2.
REQ-030 Load with no ALU: ld accepted rd=7 data=0xCAFE at N -> write rd=7 at N+2; busy[7] set by prior issue clears at N+2 edge.
REQ-031 Conflict: load rd=3 accepted N, alu_valid rd=4 at N+1 and N+2 -> writes rd=4 at N+2, N+3, rd=3 at N+4.
REQ-032 Fill: ALU valid every cycle, 4 loads pushed -> ld_ready=0 after 4th, stall_req=1 at count 3; ALU off -> drained in push order, 1 per cycle.
REQ-033 x0: alu_rd=0 and ld_rd=0 and issue_rd=0 -> no rf write, FIFO count unchanged, busy[0]=0.
REQ-034 Reset with 2 buffered loads and busy[9]=1 -> reset=0 mid-cycle clears all; after release no write for those loads appears.
